// File: rtl/duty_phase_slew_limiter.sv
// Serial slew limiter for per-channel PWM duty/phase words: on START each channel steps toward its target by at most STEP.
// Optional `SLEW_BYPASS_EN adds bypass_i, which loads the targets directly for the channel being processed.
`timescale 1ns/1ps
module duty_phase_slew_limiter #(
    parameter int WIDTH = 13,
    parameter int DEPTH = 249
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             start_i,
    input  logic [WIDTH-1:0] step_i,
    input  logic [WIDTH-1:0] cycle_i     [0:DEPTH-1],
    input  logic [WIDTH-1:0] duty_tgt_i  [0:DEPTH-1],
    input  logic [WIDTH-1:0] phase_tgt_i [0:DEPTH-1],
`ifdef SLEW_BYPASS_EN
    input  logic             bypass_i,
`endif
    output logic [WIDTH-1:0] duty_o      [0:DEPTH-1],
    output logic [WIDTH-1:0] phase_o     [0:DEPTH-1],
    output logic             busy_o,
    output logic             done_o
);

    localparam int IDXW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(DEPTH - 1);
    localparam logic [WIDTH:0]  TWO      = 2;

    typedef enum logic {S_IDLE, S_SWEEP} state_t;

    state_t            state_q, state_d;
    logic [IDXW-1:0]   idx_q, idx_d;
    logic              done_q, done_d;
    logic              wr_en;

    logic [WIDTH-1:0]  duty_q  [0:DEPTH-1];
    logic [WIDTH-1:0]  phase_q [0:DEPTH-1];

    logic [WIDTH-1:0]  duty_cur, duty_tgt, phase_cur, phase_tgt;
    logic [WIDTH-1:0]  duty_lim, phase_lim, duty_d, phase_d;
    logic [WIDTH:0]    duty_diff, step_x;
    logic [WIDTH:0]    ph_c, ph_t, ph_n, ph_half, ph_dist, ph_back, ph_move, ph_sum;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            done_q  <= done_d;
        end
    end

    // START is only honoured from idle; a pulse during a sweep is dropped.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        done_d  = 1'b0;
        wr_en   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    state_d = S_SWEEP;
                    idx_d   = '0;
                end
            end
            S_SWEEP: begin
                wr_en = 1'b1;
                if (idx_q == LAST_IDX) begin
                    state_d = S_IDLE;
                    idx_d   = '0;
                    done_d  = 1'b1;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign busy_o = (state_q == S_SWEEP);
    assign done_o = done_q;

    assign duty_cur  = duty_q[idx_q];
    assign duty_tgt  = duty_tgt_i[idx_q];
    assign phase_cur = phase_q[idx_q];
    assign phase_tgt = phase_tgt_i[idx_q];
    assign step_x    = {1'b0, step_i};

    always_comb begin
        duty_lim  = duty_cur;
        duty_diff = '0;
        if (duty_tgt > duty_cur) begin
            duty_diff = {1'b0, duty_tgt} - {1'b0, duty_cur};
            duty_lim  = (duty_diff <= step_x) ? duty_tgt : duty_cur + step_i;
        end else if (duty_tgt < duty_cur) begin
            duty_diff = {1'b0, duty_cur} - {1'b0, duty_tgt};
            duty_lim  = (duty_diff <= step_x) ? duty_tgt : duty_cur - step_i;
        end
    end

    // Phase lives on a circle of cycle_i counts; an exact half-turn resolves forward.
    always_comb begin
        ph_c      = {1'b0, phase_cur};
        ph_t      = {1'b0, phase_tgt};
        ph_n      = {1'b0, cycle_i[idx_q]};
        ph_half   = ph_n >> 1;
        ph_dist   = (ph_t >= ph_c) ? (ph_t - ph_c) : (ph_t + ph_n - ph_c);
        ph_back   = ph_n - ph_dist;
        ph_move   = '0;
        ph_sum    = ph_c;
        phase_lim = phase_cur;
        if ((ph_n < TWO) || (ph_c >= ph_n) || (ph_t >= ph_n)) begin
            phase_lim = phase_tgt;
        end else if (ph_dist == '0) begin
            phase_lim = phase_cur;
        end else if (ph_dist <= ph_half) begin
            ph_move   = (ph_dist < step_x) ? ph_dist : step_x;
            ph_sum    = ph_c + ph_move;
            if (ph_sum >= ph_n) begin
                ph_sum = ph_sum - ph_n;
            end
            phase_lim = ph_sum[WIDTH-1:0];
        end else begin
            ph_move   = (ph_back < step_x) ? ph_back : step_x;
            ph_sum    = (ph_c >= ph_move) ? (ph_c - ph_move) : (ph_c + ph_n - ph_move);
            phase_lim = ph_sum[WIDTH-1:0];
        end
    end

`ifdef SLEW_BYPASS_EN
    assign duty_d  = bypass_i ? duty_tgt  : duty_lim;
    assign phase_d = bypass_i ? phase_tgt : phase_lim;
`else
    assign duty_d  = duty_lim;
    assign phase_d = phase_lim;
`endif

    // Shared datapath result is steered into one channel per cycle by index decode.
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_chan
        always_ff @(posedge clk_i or negedge rst_n_i) begin
            if (!rst_n_i) begin
                duty_q[gi]  <= '0;
                phase_q[gi] <= '0;
            end else if (wr_en && (idx_q == IDXW'(gi))) begin
                duty_q[gi]  <= duty_d;
                phase_q[gi] <= phase_d;
            end
        end
        assign duty_o[gi]  = duty_q[gi];
        assign phase_o[gi] = phase_q[gi];
    end

endmodule
